// File: rtl/cb_pkg.sv
// Shared types and helpers for the parametrised connection blocks.
// Holds the select encoding, the load-state enum and clog2.
package cb_pkg;

    localparam int SEL_DISCONNECT = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        READY
    } load_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cb_ipin_mux.sv
// One grid input pin mux: select 0 disconnects, 1..MUX_SIZE pick a track.
// Ports: sel (pin field), bottom_in/top_in (tracks), pin (drive).
module cb_ipin_mux
    import cb_pkg::*;
#(
    parameter int MUX_SIZE    = 2,
    parameter int SEL_W       = 2,
    parameter int PIN_IDX     = 0,
    parameter int CHAN_WIDTH  = 5,
    parameter int IPIN_STRIDE = 1
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [CHAN_WIDTH-1:0] bottom_in,
    input  logic [CHAN_WIDTH-1:0] top_in,
    output logic                  pin
);

    // src[v] is the value driven for select v; even sources come
    // from below, odd from above, sharing one track per pair.
    logic [MUX_SIZE:0] src;

    assign src[SEL_DISCONNECT] = 1'b0;

    for (genvar s = 0; s < MUX_SIZE; s++) begin : g_src
        localparam int T =
            (PIN_IDX * IPIN_STRIDE + s / 2) % CHAN_WIDTH;
        if (s % 2 == 0) begin : g_bot
            assign src[s+1] = bottom_in[T];
        end else begin : g_top
            assign src[s+1] = top_in[T];
        end
    end

    always_comb begin
        pin = 1'b0;
        if (sel <= SEL_W'(MUX_SIZE)) pin = src[sel];
    end

    // Only a few tracks reach any one pin.
    logic unused_ok;
    assign unused_ok = ^{bottom_in, top_in};

endmodule

// File: rtl/cby_param_cfg.sv
// Parametrised Y connection block with shadow scan chain and commit.
// Ports: prog_clk/pReset, chany_* tracks, ipin_out, ccff_* chain, cfg_* status.
module cby_param_cfg
    import cb_pkg::*;
#(
    parameter int CHAN_WIDTH  = 5,
    parameter int NUM_IPIN    = 3,
    parameter int MUX_SIZE    = 2,
    parameter int IPIN_STRIDE = 1
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
    input  logic                  ccff_head,
    input  logic                  ccff_en,
    input  logic                  cfg_commit,
    output logic                  ccff_tail,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic                  cfg_ovf
);

    localparam int SEL_W    = clog2(MUX_SIZE + 1);
    localparam int CFG_BITS = NUM_IPIN * SEL_W;
    localparam int CNT_W    = clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    load_state_e         state;
    load_state_e         state_nxt;
    logic                commit_ok;

    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    assign commit_ok = cfg_commit && (state == READY);

    // A shift in the commit cycle is the first bit of the next stream.
    always_comb begin
        cnt_nxt   = bit_cnt;
        state_nxt = SHIFT;
        if (commit_ok) begin
            cnt_nxt = ccff_en ? CNT_W'(1) : '0;
        end else if (ccff_en && bit_cnt != CNT_MAX) begin
            cnt_nxt = bit_cnt + CNT_W'(1);
        end
        if (cnt_nxt == '0) begin
            state_nxt = IDLE;
        end else if (cnt_nxt == CNT_MAX) begin
            state_nxt = READY;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            shadow    <= '0;
            active    <= '0;
            bit_cnt   <= '0;
            ccff_tail <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ovf   <= 1'b0;
        end else begin
            if (ccff_en) begin
                shadow <= {shadow[CFG_BITS-2:0], ccff_head};
            end
            ccff_tail <= shadow[CFG_BITS-1];
            bit_cnt   <= cnt_nxt;
            cfg_err   <= cfg_commit && !commit_ok;
            if (commit_ok) begin
                active   <= shadow;
                cfg_done <= 1'b1;
                cfg_ovf  <= 1'b0;
            end else if (ccff_en && state == READY) begin
                cfg_ovf <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
        cb_ipin_mux #(
            .MUX_SIZE   (MUX_SIZE),
            .SEL_W      (SEL_W),
            .PIN_IDX    (i),
            .CHAN_WIDTH (CHAN_WIDTH),
            .IPIN_STRIDE(IPIN_STRIDE)
        ) u_mux (
            .sel      (active[i*SEL_W +: SEL_W]),
            .bottom_in(chany_bottom_in),
            .top_in   (chany_top_in),
            .pin      (ipin_out[i])
        );
    end

endmodule

// File: tb/tb_cby_param_cfg.sv
// Bench for cby_param_cfg: directed table, hand sequences, random vs model.
// A second instance covers a wider parameter set.
module tb_cby_param_cfg;

    localparam int CFG = 6;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic [4:0] bin, tin, top_out, bot_out;
    logic [2:0] ipin;
    logic       head, en, commit, tail, done, err, ovf;

    logic [7:0] b2, t2, to2, bo2;
    logic [3:0] ipin2;
    logic       head2, en2, commit2, tail2, done2, err2, ovf2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 prog_clk = ~prog_clk;

    cby_param_cfg dut (
        .prog_clk(prog_clk), .pReset(pReset),
        .chany_bottom_in(bin), .chany_top_in(tin),
        .chany_top_out(top_out), .chany_bottom_out(bot_out),
        .ipin_out(ipin), .ccff_head(head), .ccff_en(en),
        .cfg_commit(commit), .ccff_tail(tail),
        .cfg_done(done), .cfg_err(err), .cfg_ovf(ovf)
    );

    cby_param_cfg #(
        .CHAN_WIDTH(8), .NUM_IPIN(4), .MUX_SIZE(5), .IPIN_STRIDE(3)
    ) dut2 (
        .prog_clk(prog_clk), .pReset(pReset),
        .chany_bottom_in(b2), .chany_top_in(t2),
        .chany_top_out(to2), .chany_bottom_out(bo2),
        .ipin_out(ipin2), .ccff_head(head2), .ccff_en(en2),
        .cfg_commit(commit2), .ccff_tail(tail2),
        .cfg_done(done2), .cfg_err(err2), .cfg_ovf(ovf2)
    );

    // Model: the shifted bit stream, shifts since commit, committed fields.
    bit stream[$];
    int m_n;
    bit m_done;
    int act[3];
    bit exp_tail;
    bit exp_err;

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic bit sh_bit(input int j);
        if (stream.size() > j) return stream[stream.size() - 1 - j];
        return 1'b0;
    endfunction

    function automatic int field(input int i, input int sw);
        int v;
        v = 0;
        for (int b = 0; b < sw; b++) v |= int'(sh_bit(i * sw + b)) << b;
        return v;
    endfunction

    function automatic bit pin_exp(input int i, input int v, input int cw,
                                   input int ms, input int st,
                                   input logic [7:0] b,
                                   input logic [7:0] t);
        int s, tt;
        if (v == 0 || v > ms) return 1'b0;
        s  = v - 1;
        tt = (i * st + s / 2) % cw;
        return (s % 2 == 0) ? b[tt] : t[tt];
    endfunction

    function automatic logic [2:0] ipin_model();
        logic [2:0] r;
        for (int i = 0; i < 3; i++)
            r[i] = pin_exp(i, act[i], 5, 2, 1, 8'(bin), 8'(tin));
        return r;
    endfunction

    task automatic model_reset();
        stream.delete();
        m_n = 0;
        m_done = 0;
        exp_tail = 0;
        exp_err = 0;
        for (int i = 0; i < 3; i++) act[i] = 0;
    endtask

    task automatic step(input bit en_i, input bit h_i, input bit c_i,
                        input logic [4:0] b_i, input logic [4:0] t_i);
        bit acc;
        en = en_i; head = h_i; commit = c_i; bin = b_i; tin = t_i;
        acc      = c_i && (m_n >= CFG);
        exp_err  = c_i && !acc;
        exp_tail = sh_bit(CFG - 1);
        if (acc) begin
            for (int i = 0; i < 3; i++) act[i] = field(i, 2);
            m_done = 1;
        end
        if (en_i) stream.push_back(h_i);
        if (acc) m_n = en_i ? 1 : 0;
        else if (en_i) m_n++;
        @(posedge prog_clk);
        #1;
        chk("ipin", 32'(ipin), 32'(ipin_model()));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(exp_err));
        chk("ovf", 32'(ovf), 32'(m_n > CFG));
        chk("tail", 32'(tail), 32'(exp_tail));
        chk("top_out", 32'(top_out), 32'(bin));
        chk("bot_out", 32'(bot_out), 32'(tin));
    endtask

    typedef struct {
        bit         en;
        bit         h;
        bit         c;
        logic [4:0] b;
        logic [4:0] t;
        logic [2:0] e_ipin;
        bit         e_done;
        bit         e_err;
    } vec_t;

    vec_t tbl[10];

    task automatic load2(input int v3);
        for (int k = 0; k < 12; k++) begin
            int j;
            j = 11 - k;
            en2 = 1'b1;
            head2 = (j >= 9) ? ((v3 >> (j - 9)) & 1) != 0 : 1'b0;
            @(posedge prog_clk);
            #1;
        end
        en2 = 1'b0;
        commit2 = 1'b1;
        @(posedge prog_clk);
        #1;
        commit2 = 1'b0;
        chk("d2_done", 32'(done2), 32'd1);
        chk("d2_err", 32'(err2), 32'd0);
    endtask

    task automatic chk2(input int v3, input logic [7:0] b,
                        input logic [7:0] t);
        logic [3:0] e;
        b2 = b; t2 = t;
        #1;
        for (int i = 0; i < 4; i++)
            e[i] = pin_exp(i, (i == 3) ? v3 : 0, 8, 5, 3, b, t);
        chk("d2_ipin", 32'(ipin2), 32'(e));
    endtask

    initial begin
        logic [7:0] obits;
        logic [7:0] otail;

        tbl[0] = '{1, 0, 0, 5'h02, 5'h01, 3'b000, 0, 0};
        tbl[1] = '{1, 0, 0, 5'h02, 5'h01, 3'b000, 0, 0};
        tbl[2] = '{1, 0, 0, 5'h02, 5'h01, 3'b000, 0, 0};
        tbl[3] = '{0, 0, 1, 5'h02, 5'h01, 3'b000, 0, 1};
        tbl[4] = '{0, 0, 0, 5'h02, 5'h01, 3'b000, 0, 0};
        tbl[5] = '{1, 1, 0, 5'h02, 5'h01, 3'b000, 0, 0};
        tbl[6] = '{1, 1, 0, 5'h02, 5'h01, 3'b000, 0, 0};
        tbl[7] = '{1, 0, 0, 5'h02, 5'h01, 3'b000, 0, 0};
        tbl[8] = '{0, 0, 1, 5'h02, 5'h01, 3'b011, 1, 0};
        tbl[9] = '{0, 0, 0, 5'h02, 5'h00, 3'b010, 1, 0};

        pReset = 0;
        en = 0; head = 0; commit = 0; bin = 0; tin = 0;
        en2 = 0; head2 = 0; commit2 = 0; b2 = 0; t2 = 0;
        model_reset();
        repeat (3) @(posedge prog_clk);
        bin = 5'b10110;
        tin = 5'b01001;
        #1;
        chk("rst_top_out", 32'(top_out), 32'h16);
        chk("rst_bot_out", 32'(bot_out), 32'h09);
        chk("rst_ipin", 32'(ipin), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tail", 32'(tail), 32'd0);
        @(negedge prog_clk);
        pReset = 1;
        #1;

        for (int r = 0; r < 10; r++) begin
            step(tbl[r].en, tbl[r].h, tbl[r].c, tbl[r].b, tbl[r].t);
            chk($sformatf("tbl%0d_ipin", r), 32'(ipin), 32'(tbl[r].e_ipin));
            chk($sformatf("tbl%0d_done", r), 32'(done), 32'(tbl[r].e_done));
            chk($sformatf("tbl%0d_err", r), 32'(err), 32'(tbl[r].e_err));
        end

        // Overflow with tail replay; routing must hold until commit.
        obits = 8'b10110010;
        otail = 8'b00011010;
        for (int k = 0; k < 8; k++) begin
            step(1, obits[7-k], 0, 5'h02, 5'h01);
            chk("ovf_hold_ipin", 32'(ipin), 32'b011);
            chk("ovf_flag", 32'(ovf), 32'(k >= 6));
            chk("ovf_tail", 32'(tail), 32'(otail[7-k]));
        end
        step(0, 0, 1, 5'h02, 5'h01);
        chk("ovf_clear", 32'(ovf), 32'd0);
        chk("ovf_new_ipin", 32'(ipin), 32'b001);

        // Shift and commit in the same cycle.
        step(1, 0, 0, 5'h06, 5'h00);
        step(1, 1, 0, 5'h06, 5'h00);
        step(1, 0, 0, 5'h06, 5'h00);
        step(1, 1, 0, 5'h06, 5'h00);
        step(1, 1, 0, 5'h06, 5'h00);
        step(1, 0, 0, 5'h06, 5'h00);
        step(1, 1, 1, 5'h06, 5'h00);
        chk("sim_ipin", 32'(ipin), 32'b110);
        chk("sim_err", 32'(err), 32'd0);
        step(0, 0, 1, 5'h06, 5'h00);
        chk("sim_shift_state", 32'(err), 32'd1);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 5'h1f, 5'h00);
        step(0, 0, 1, 5'h1f, 5'h00);
        chk("sim_reload_err", 32'(err), 32'd0);

        // Asynchronous reset in the middle of operation.
        @(negedge prog_clk);
        #2;
        pReset = 0;
        #1;
        chk("arst_ipin", 32'(ipin), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_tail", 32'(tail), 32'd0);
        chk("arst_pass", 32'(top_out), 32'(bin));
        model_reset();
        @(negedge prog_clk);
        pReset = 1;

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom),
                 $urandom_range(0, 7) == 0,
                 5'($urandom), 5'($urandom));
        end
        en = 0;
        commit = 0;

        // Wider parameter set on the second instance.
        load2(5);
        chk2(5, 8'h08, 8'h00);
        chk("d2_v5_hand", 32'(ipin2), 32'b1000);
        chk2(5, 8'hF7, 8'hFF);
        load2(4);
        chk2(4, 8'h00, 8'h04);
        chk2(4, 8'hFF, 8'hFB);
        load2(6);
        chk2(6, 8'hFF, 8'hFF);
        load2(7);
        chk2(7, 8'hFF, 8'hFF);
        chk("d2_v7_hand", 32'(ipin2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
